// File: rtl/mem_stage_pkg.sv
// mem_stage shared types: FSM states, EX/MEM record and the alignment helper.
package mem_stage_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT_RSP
    } state_e;

    localparam logic [2:0] ALIGN_MASK = 3'b111;

    typedef struct packed {
        logic        branch;
        logic        zero;
        logic        mem_read;
        logic        mem_write;
        logic        reg_write;
        logic        mem_to_reg;
        logic [4:0]  rd;
        logic [63:0] add_out;
        logic [63:0] alu_result;
        logic [63:0] write_data;
    } ex_mem_t;

    function automatic logic misaligned(input logic [63:0] addr);
        return (addr[2:0] & ALIGN_MASK) != 3'b000;
    endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory port: valid/ready request channel plus a load response channel.
interface mem_stage_if;

    logic        req_valid;
    logic        req_ready;
    logic        we;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic        rsp_valid;
    logic [63:0] rdata;

    modport master (
        output req_valid,
        output we,
        output addr,
        output wdata,
        input  req_ready,
        input  rsp_valid,
        input  rdata
    );

    modport slave (
        input  req_valid,
        input  we,
        input  addr,
        input  wdata,
        output req_ready,
        output rsp_valid,
        output rdata
    );

endinterface

// File: rtl/mem_req_ctrl.sv
// Memory access FSM with load timeout; owns ex_ready, dmem request valid
// and the retire strobe for the held instruction.
module mem_req_ctrl
    import mem_stage_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ex_valid,
    input  logic mem_op,
    input  logic misalign,
    input  logic is_load,
    input  logic req_ready,
    input  logic rsp_valid,
    output logic ex_ready,
    output logic req_valid,
    output logic capture,
    output logic rsp_take,
    output logic timeout,
    output logic retire
);

    localparam int CW =
        (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES - 1);

    state_e        st_d, st_q;
    logic [CW-1:0] cnt_d, cnt_q;
    logic          rdy_d, rdy_q;
    logic          req_d, req_q;
    logic          ret_d, ret_q;

    always_comb begin
        capture  = ex_valid && rdy_q;
        rsp_take = (st_q == WAIT_RSP) && rsp_valid;
        timeout  = (st_q == WAIT_RSP) && !rsp_valid
                   && (cnt_q == LIMIT);
        st_d  = st_q;
        cnt_d = cnt_q;
        ret_d = 1'b0;
        unique case (st_q)
            IDLE: begin
                if (capture) begin
                    if (mem_op && !misalign) st_d = REQ;
                    else                     ret_d = 1'b1;
                end
            end
            REQ: begin
                if (req_q && req_ready) begin
                    if (is_load) begin
                        st_d  = WAIT_RSP;
                        cnt_d = '0;
                    end else begin
                        // stores are posted: no response expected
                        st_d  = IDLE;
                        ret_d = 1'b1;
                    end
                end
            end
            WAIT_RSP: begin
                if (rsp_take || timeout) begin
                    st_d  = IDLE;
                    cnt_d = '0;
                    ret_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: st_d = IDLE;
        endcase
        rdy_d = (st_d == IDLE);
        req_d = (st_d == REQ);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q  <= IDLE;
            cnt_q <= '0;
            rdy_q <= 1'b0;
            req_q <= 1'b0;
            ret_q <= 1'b0;
        end else begin
            st_q  <= st_d;
            cnt_q <= cnt_d;
            rdy_q <= rdy_d;
            req_q <= req_d;
            ret_q <= ret_d;
        end
    end

    assign ex_ready  = rdy_q;
    assign req_valid = req_q;
    assign retire    = ret_q;

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: EX/MEM register, branch resolve, LDUR/STUR over the
// dmem port and registered MEM/WB outputs.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter bit          CHECK_ALIGN    = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ex_valid,
    output logic        ex_ready,
    input  logic [63:0] ex_add_out,
    input  logic        ex_zero,
    input  logic [63:0] ex_alu_result,
    input  logic [63:0] ex_write_data,
    input  logic        ex_branch,
    input  logic        ex_mem_read,
    input  logic        ex_mem_write,
    input  logic        ex_reg_write,
    input  logic        ex_mem_to_reg,
    input  logic [4:0]  ex_rd,
    mem_stage_if.master dmem,
    output logic        pc_src,
    output logic [63:0] branch_target,
    output logic        wb_valid,
    output logic        wb_reg_write,
    output logic [4:0]  wb_rd,
    output logic [63:0] wb_data,
    output logic        wb_fault
);

    ex_mem_t     exm_d, exm_q;
    logic        fresh_d, fresh_q;
    logic        flt_d, flt_q;
    logic [63:0] rdata_d, rdata_q;
    logic        wbv_d, wbv_q;
    logic        wbw_d, wbw_q;
    logic [4:0]  wbr_d, wbr_q;
    logic [63:0] wbd_d, wbd_q;
    logic        wbf_d, wbf_q;

    logic capture, rsp_take, timeout, retire;
    logic mem_op, misalign;

    assign mem_op   = ex_mem_read || ex_mem_write;
    assign misalign = CHECK_ALIGN && misaligned(ex_alu_result);

    mem_req_ctrl #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_ctrl (
        .clk       (clk),
        .rst_n     (rst_n),
        .ex_valid  (ex_valid),
        .mem_op    (mem_op),
        .misalign  (misalign),
        .is_load   (exm_q.mem_read),
        .req_ready (dmem.req_ready),
        .rsp_valid (dmem.rsp_valid),
        .ex_ready  (ex_ready),
        .req_valid (dmem.req_valid),
        .capture   (capture),
        .rsp_take  (rsp_take),
        .timeout   (timeout),
        .retire    (retire)
    );

    // read+write together behaves as a load
    assign dmem.we    = exm_q.mem_write && !exm_q.mem_read;
    assign dmem.addr  = exm_q.alu_result;
    assign dmem.wdata = exm_q.write_data;

    assign pc_src        = fresh_q && exm_q.branch && exm_q.zero;
    assign branch_target = exm_q.add_out;

    always_comb begin
        exm_d   = exm_q;
        fresh_d = capture;
        flt_d   = flt_q;
        rdata_d = rsp_take ? dmem.rdata : rdata_q;
        if (capture) begin
            exm_d.branch     = ex_branch;
            exm_d.zero       = ex_zero;
            exm_d.mem_read   = ex_mem_read;
            exm_d.mem_write  = ex_mem_write;
            exm_d.reg_write  = ex_reg_write;
            exm_d.mem_to_reg = ex_mem_to_reg;
            exm_d.rd         = ex_rd;
            exm_d.add_out    = ex_add_out;
            exm_d.alu_result = ex_alu_result;
            exm_d.write_data = ex_write_data;
            flt_d            = mem_op && misalign;
        end else if (timeout) begin
            flt_d = 1'b1;
        end
    end

    always_comb begin
        wbv_d = retire;
        wbw_d = wbw_q;
        wbr_d = wbr_q;
        wbd_d = wbd_q;
        wbf_d = wbf_q;
        if (retire) begin
            wbw_d = exm_q.reg_write && !flt_q;
            wbr_d = exm_q.rd;
            wbd_d = exm_q.mem_to_reg ? rdata_q
                                     : exm_q.alu_result;
            wbf_d = flt_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exm_q   <= '0;
            fresh_q <= 1'b0;
            flt_q   <= 1'b0;
            rdata_q <= '0;
            wbv_q   <= 1'b0;
            wbw_q   <= 1'b0;
            wbr_q   <= '0;
            wbd_q   <= '0;
            wbf_q   <= 1'b0;
        end else begin
            exm_q   <= exm_d;
            fresh_q <= fresh_d;
            flt_q   <= flt_d;
            rdata_q <= rdata_d;
            wbv_q   <= wbv_d;
            wbw_q   <= wbw_d;
            wbr_q   <= wbr_d;
            wbd_q   <= wbd_d;
            wbf_q   <= wbf_d;
        end
    end

    assign wb_valid     = wbv_q;
    assign wb_reg_write = wbw_q;
    assign wb_rd        = wbr_q;
    assign wb_data      = wbd_q;
    assign wb_fault     = wbf_q;

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: directed instructions, a scripted
// memory responder and a write-back monitor.
module tb_mem_stage;

    localparam int TMO = 255;

    logic        clk, rst_n;
    logic        ex_valid, ex_ready;
    logic [63:0] ex_add_out, ex_alu_result, ex_write_data;
    logic        ex_zero, ex_branch, ex_mem_read, ex_mem_write;
    logic        ex_reg_write, ex_mem_to_reg;
    logic [4:0]  ex_rd;
    logic        pc_src;
    logic [63:0] branch_target;
    logic        wb_valid, wb_reg_write, wb_fault;
    logic [4:0]  wb_rd;
    logic [63:0] wb_data;

    mem_stage_if dmem ();

    mem_stage #(
        .TIMEOUT_CYCLES(TMO),
        .CHECK_ALIGN   (1'b1)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ex_valid     (ex_valid),
        .ex_ready     (ex_ready),
        .ex_add_out   (ex_add_out),
        .ex_zero      (ex_zero),
        .ex_alu_result(ex_alu_result),
        .ex_write_data(ex_write_data),
        .ex_branch    (ex_branch),
        .ex_mem_read  (ex_mem_read),
        .ex_mem_write (ex_mem_write),
        .ex_reg_write (ex_reg_write),
        .ex_mem_to_reg(ex_mem_to_reg),
        .ex_rd        (ex_rd),
        .dmem         (dmem.master),
        .pc_src       (pc_src),
        .branch_target(branch_target),
        .wb_valid     (wb_valid),
        .wb_reg_write (wb_reg_write),
        .wb_rd        (wb_rd),
        .wb_data      (wb_data),
        .wb_fault     (wb_fault)
    );

    typedef struct {
        int          cyc;
        logic [4:0]  rd;
        logic [63:0] data;
        logic        rw;
        logic        flt;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    // responder configuration, written by stimulus only
    int          stall_cfg = 0;
    int          rsp_dly = 1;
    bit          rsp_en = 1;
    logic [63:0] rsp_data = '0;
    logic [63:0] exp_addr = '0;
    logic [63:0] exp_wdata = '0;
    logic        exp_we = 1'b0;
    int          req_seen = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h t=%0t",
                     name, act, exp, $time);
        end
    endtask

    // write-back monitor
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && wb_valid) begin
            if (sb.size() == 0) begin
                chk("wb_unexpected", 64'(wb_valid), 64'(0));
            end else begin
                e = sb.pop_front();
                chk("wb_cycle", 64'(cyc), 64'(e.cyc));
                chk("wb_rd", 64'(wb_rd), 64'(e.rd));
                chk("wb_reg_write", 64'(wb_reg_write), 64'(e.rw));
                chk("wb_fault", 64'(wb_fault), 64'(e.flt));
                if (!e.flt) chk("wb_data", wb_data, e.data);
            end
        end
    end

    // data memory model
    initial begin
        bit          in_req;
        int          stall_cnt, rsp_cnt;
        logic [63:0] l_addr, l_wdata;
        logic        l_we;
        in_req = 0;
        stall_cnt = 0;
        rsp_cnt = 0;
        l_addr = '0;
        l_wdata = '0;
        l_we = 1'b0;
        dmem.req_ready = 1'b0;
        dmem.rsp_valid = 1'b0;
        dmem.rdata = '0;
        forever begin
            @(negedge clk);
            dmem.req_ready = 1'b0;
            dmem.rsp_valid = 1'b0;
            if (!rst_n) begin
                in_req = 0;
                rsp_cnt = 0;
            end else begin
                if (rsp_cnt > 0) begin
                    rsp_cnt--;
                    if (rsp_cnt == 0) begin
                        dmem.rsp_valid = 1'b1;
                        dmem.rdata = rsp_data;
                    end
                end
                if (dmem.req_valid) begin
                    chk("ex_ready_stall", 64'(ex_ready), 64'(0));
                    if (!in_req) begin
                        in_req = 1;
                        req_seen++;
                        stall_cnt = stall_cfg;
                        l_addr = dmem.addr;
                        l_wdata = dmem.wdata;
                        l_we = dmem.we;
                        chk("req_addr", dmem.addr, exp_addr);
                        chk("req_we", 64'(dmem.we), 64'(exp_we));
                        if (exp_we)
                            chk("req_wdata", dmem.wdata, exp_wdata);
                    end else begin
                        chk("hold_addr", dmem.addr, l_addr);
                        chk("hold_wdata", dmem.wdata, l_wdata);
                        chk("hold_we", 64'(dmem.we), 64'(l_we));
                    end
                    if (stall_cnt == 0) begin
                        dmem.req_ready = 1'b1;
                        in_req = 0;
                        if (!dmem.we && rsp_en) rsp_cnt = rsp_dly;
                    end else begin
                        stall_cnt--;
                    end
                end
            end
        end
    end

    task automatic issue(input logic [63:0] add_out,
                         input logic [63:0] alu,
                         input logic [63:0] wdata,
                         input logic br, z, mr, mw, rw, m2r,
                         input logic [4:0] rd,
                         input int lat,
                         input logic [63:0] exp_data,
                         input logic exp_flt,
                         input bit push,
                         output int cap);
        int n;
        ex_add_out = add_out;
        ex_alu_result = alu;
        ex_write_data = wdata;
        ex_branch = br;
        ex_zero = z;
        ex_mem_read = mr;
        ex_mem_write = mw;
        ex_reg_write = rw;
        ex_mem_to_reg = m2r;
        ex_rd = rd;
        ex_valid = 1'b1;
        n = 0;
        while (!ex_ready && n < 600) begin
            @(negedge clk);
            n++;
        end
        if (!ex_ready) begin
            chk("ex_ready_wait", 64'(ex_ready), 64'(1));
            ex_valid = 1'b0;
            cap = 0;
            return;
        end
        cap = cyc + 1;
        if (push)
            sb.push_back('{cap + lat, rd, exp_data,
                           rw && !exp_flt, exp_flt});
        @(negedge clk);
        ex_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int c1, c2, rq;
        rst_n = 1'b0;
        ex_valid = 1'b0;
        ex_add_out = '0;
        ex_alu_result = '0;
        ex_write_data = '0;
        ex_branch = 1'b0;
        ex_zero = 1'b0;
        ex_mem_read = 1'b0;
        ex_mem_write = 1'b0;
        ex_reg_write = 1'b0;
        ex_mem_to_reg = 1'b0;
        ex_rd = '0;
        idle(2);
        chk("rst_ex_ready", 64'(ex_ready), 64'(0));
        chk("rst_req_valid", 64'(dmem.req_valid), 64'(0));
        chk("rst_wb_valid", 64'(wb_valid), 64'(0));
        chk("rst_pc_src", 64'(pc_src), 64'(0));
        chk("rst_wb_data", wb_data, 64'(0));
        rst_n = 1'b1;
        idle(2);

        // ADD back-to-back
        issue(0, 64'h1234, 0, 0, 0, 0, 0, 1, 0, 5'd3,
              1, 64'h1234, 0, 1, c1);
        issue(0, 64'h55, 0, 0, 0, 0, 0, 1, 0, 5'd4,
              1, 64'h55, 0, 1, c2);
        chk("b2b_capture", 64'(c2), 64'(c1 + 1));
        idle(2);

        // CBZ taken
        issue(64'h400, 0, 0, 1, 1, 0, 0, 0, 0, 5'd0,
              1, 64'h0, 0, 1, c1);
        chk("cbz_pc_src", 64'(pc_src), 64'(1));
        chk("cbz_target", branch_target, 64'h400);
        idle(1);
        chk("cbz_pc_src_off", 64'(pc_src), 64'(0));
        chk("cbz_target_hold", branch_target, 64'h400);
        // CBZ not taken
        issue(64'h800, 64'h9, 0, 1, 0, 0, 0, 0, 0, 5'd0,
              1, 64'h9, 0, 1, c1);
        chk("cbnz_pc_src", 64'(pc_src), 64'(0));
        idle(1);
        chk("cbnz_pc_src2", 64'(pc_src), 64'(0));

        // STUR with 3-cycle stall
        stall_cfg = 3;
        exp_addr = 64'h100;
        exp_wdata = 64'hDEADBEEF;
        exp_we = 1'b1;
        issue(0, 64'h100, 64'hDEADBEEF, 0, 0, 0, 1, 0, 0, 5'd0,
              5, 64'h100, 0, 1, c1);
        chk("st_ex_ready", 64'(ex_ready), 64'(0));
        idle(6);

        // STUR no stall
        stall_cfg = 0;
        exp_addr = 64'h18;
        exp_wdata = 64'h77;
        issue(0, 64'h18, 64'h77, 0, 0, 0, 1, 0, 0, 5'd0,
              2, 64'h18, 0, 1, c1);
        idle(3);

        // LDUR, response two cycles after handshake
        exp_addr = 64'h208;
        exp_we = 1'b0;
        rsp_dly = 2;
        rsp_data = 64'hCAFE;
        issue(0, 64'h208, 0, 0, 0, 1, 0, 1, 1, 5'd5,
              4, 64'hCAFE, 0, 1, c1);
        idle(5);

        // LDUR, response one cycle after handshake
        exp_addr = 64'h10;
        rsp_dly = 1;
        rsp_data = 64'h1111_2222_3333_4444;
        issue(0, 64'h10, 0, 0, 0, 1, 0, 1, 1, 5'd7,
              3, 64'h1111_2222_3333_4444, 0, 1, c1);
        idle(4);

        // read+write together acts as a load
        exp_addr = 64'h20;
        rsp_data = 64'hABCD;
        issue(0, 64'h20, 64'h99, 0, 0, 1, 1, 1, 1, 5'd8,
              3, 64'hABCD, 0, 1, c1);
        idle(4);

        // misaligned load never requests
        rq = req_seen;
        issue(0, 64'h203, 0, 0, 0, 1, 0, 1, 1, 5'd9,
              1, 64'h0, 1, 1, c1);
        idle(3);
        chk("misalign_no_req", 64'(req_seen), 64'(rq));

        // load timeout
        rsp_en = 0;
        exp_addr = 64'h300;
        issue(0, 64'h300, 0, 0, 0, 1, 0, 1, 1, 5'd10,
              2 + TMO, 64'h0, 1, 1, c1);
        idle(TMO + 4);
        chk("tmo_ex_ready", 64'(ex_ready), 64'(1));
        rsp_en = 1;

        // asynchronous reset during REQ
        stall_cfg = 10;
        exp_addr = 64'h40;
        exp_wdata = 64'h55;
        exp_we = 1'b1;
        issue(0, 64'h40, 64'h55, 0, 0, 0, 1, 0, 0, 5'd0,
              0, 64'h0, 0, 0, c1);
        chk("pre_rst_req", 64'(dmem.req_valid), 64'(1));
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_req_valid", 64'(dmem.req_valid), 64'(0));
        chk("arst_ex_ready", 64'(ex_ready), 64'(0));
        chk("arst_wb_data", wb_data, 64'(0));
        chk("arst_wb_rd", 64'(wb_rd), 64'(0));
        chk("arst_target", branch_target, 64'(0));
        chk("arst_addr", dmem.addr, 64'(0));
        idle(2);
        rst_n = 1'b1;
        stall_cfg = 0;
        issue(0, 64'hBEEF, 0, 0, 0, 0, 0, 1, 0, 5'd11,
              1, 64'hBEEF, 0, 1, c1);
        idle(3);
        chk("post_rst_req", 64'(dmem.req_valid), 64'(0));

        chk("sb_drained", 64'(sb.size()), 64'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
